// File: rtl/perceptron_train_pkg.sv
// Shared perceptron predictor definitions: geometry, training threshold,
// weight/row types, direction constants and the training FSM encoding.
package perceptron_train_pkg;

    localparam int PERCEPTRON_NUMBER = 62;
    localparam int WIDTH             = 8;
    localparam int TABLE_DEPTH       = 64;
    localparam int IDX_W             = $clog2(TABLE_DEPTH);
    localparam int LANES             = 8;
    localparam int N_STEPS           = (PERCEPTRON_NUMBER + LANES - 1) / LANES;
    localparam int STEP_W            = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int POS_W             = $clog2(PERCEPTRON_NUMBER);
    localparam int THRESHOLD         = 133;

    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    typedef logic signed [WIDTH-1:0] weight_t;
    typedef logic [PERCEPTRON_NUMBER-1:0][WIDTH-1:0] row_t;

    localparam weight_t W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam weight_t W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECIDE = 3'd1,
        ST_UPDATE = 3'd2,
        ST_SKIP   = 3'd3,
        ST_COMMIT = 3'd4
    } train_state_e;

    // Magnitude of the prediction-time sum; 33 bits so that -2^31 stays positive.
    function automatic logic [32:0] sum_magnitude(input logic signed [31:0] s);
        logic signed [32:0] e;
        e = {s[31], s};
        return e[32] ? 33'(-e) : 33'(e);
    endfunction

endpackage

// File: rtl/perceptron_train_if.sv
// Bundle between the perceptron table and its users: combinational row read
// for prediction plus the update request channel from branch resolution.
interface perceptron_train_if;
    import perceptron_train_pkg::*;

    logic [IDX_W-1:0]             pred_index;
    row_t                         pred_weights;

    // Update channel: a request transfers on a rising edge where upd_valid and
    // upd_ready are both high; the requester holds valid and payload until then.
    logic                         upd_valid;
    logic                         upd_ready;
    logic [IDX_W-1:0]             upd_index;
    logic [PERCEPTRON_NUMBER-1:0] upd_history;
    logic                         upd_outcome;
    logic signed [31:0]           upd_sum;
    logic                         upd_done;
    logic                         upd_trained;

    modport master (
        output pred_index, upd_valid, upd_index, upd_history, upd_outcome, upd_sum,
        input  pred_weights, upd_ready, upd_done, upd_trained
    );

    modport slave (
        input  pred_index, upd_valid, upd_index, upd_history, upd_outcome, upd_sum,
        output pred_weights, upd_ready, upd_done, upd_trained
    );

endinterface

// File: rtl/perceptron_sat_lane.sv
// One training lane: nudges a signed weight by +1 or -1 and clamps it to the
// representable range instead of wrapping.
module perceptron_sat_lane
    import perceptron_train_pkg::*;
(
    input  weight_t weight,
    input  logic    up,
    output weight_t result
);

    logic [WIDTH:0] sum_ext;

    always_comb begin
        sum_ext = {weight[WIDTH-1], weight} + (up ? (WIDTH+1)'(1) : {(WIDTH+1){1'b1}});
        // The two top bits disagree only when the step left the WIDTH-bit range.
        unique case (sum_ext[WIDTH:WIDTH-1])
            2'b01:   result = W_MAX;
            2'b10:   result = W_MIN;
            default: result = weight_t'(sum_ext[WIDTH-1:0]);
        endcase
    end

endmodule

// File: rtl/perceptron_train.sv
// Perceptron weight table with a combinational prediction read port and a
// lane-serial saturating trainer that commits a whole row in a single edge.
module perceptron_train
    import perceptron_train_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    perceptron_train_if.slave bus,
    output train_state_e      dbg_state
);

    row_t                         table_q [TABLE_DEPTH];
    row_t                         shadow_q;
    train_state_e                 state_q;
    logic [IDX_W-1:0]             index_q;
    logic [PERCEPTRON_NUMBER-1:0] history_q;
    logic                         outcome_q;
    logic signed [31:0]           sum_q;
    logic [STEP_W-1:0]            step_q;
    logic                         ready_q;
    logic                         done_q;
    logic                         trained_q;

    logic                         predicted;
    logic                         train;

    weight_t                      lane_in  [LANES];
    weight_t                      lane_out [LANES];
    logic                         lane_up  [LANES];
    logic                         lane_en  [LANES];
    logic [POS_W-1:0]             lane_pos [LANES];

    assign bus.pred_weights = table_q[bus.pred_index];
    assign bus.upd_ready    = ready_q;
    assign bus.upd_done     = done_q;
    assign bus.upd_trained  = trained_q;
    assign dbg_state        = state_q;

    always_comb begin
        predicted = ~sum_q[31];
        train     = (predicted != outcome_q) || (sum_magnitude(sum_q) <= 33'(THRESHOLD));
    end

    // Lanes beyond the last weight of the final partial step are held idle.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_en[l]  = (int'(step_q) * LANES + l) < PERCEPTRON_NUMBER;
            lane_pos[l] = POS_W'(int'(step_q) * LANES + l);
            lane_in[l]  = lane_en[l] ? weight_t'(shadow_q[lane_pos[l]]) : '0;
            lane_up[l]  = lane_en[l] ? (history_q[lane_pos[l]] == outcome_q) : 1'b0;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        perceptron_sat_lane u_lane (
            .weight (lane_in[g]),
            .up     (lane_up[g]),
            .result (lane_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < TABLE_DEPTH; r++) begin
                table_q[r] <= '0;
            end
            shadow_q  <= '0;
            state_q   <= ST_IDLE;
            index_q   <= '0;
            history_q <= '0;
            outcome_q <= NOT_TAKEN;
            sum_q     <= '0;
            step_q    <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            trained_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            trained_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.upd_valid) begin
                        index_q   <= bus.upd_index;
                        history_q <= bus.upd_history;
                        outcome_q <= bus.upd_outcome;
                        sum_q     <= bus.upd_sum;
                        ready_q   <= 1'b0;
                        state_q   <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    shadow_q <= table_q[index_q];
                    step_q   <= '0;
                    if (train) begin
                        state_q <= ST_UPDATE;
                    end else begin
                        state_q <= ST_SKIP;
                        done_q  <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_en[l]) begin
                            shadow_q[lane_pos[l]] <= lane_out[l];
                        end
                    end
                    if (step_q == STEP_W'(N_STEPS - 1)) begin
                        state_q   <= ST_COMMIT;
                        done_q    <= 1'b1;
                        trained_q <= 1'b1;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                ST_SKIP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                ST_COMMIT: begin
                    // Whole-row write: readers see either the old or the new row, never a blend.
                    table_q[index_q] <= shadow_q;
                    step_q           <= '0;
                    state_q          <= ST_IDLE;
                    ready_q          <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_train.sv
// Bench for perceptron_train: directed and random training requests checked
// against an integer-arithmetic model of the weight table.
module tb_perceptron_train;
    import perceptron_train_pkg::*;

    localparam int STEPS_REF = (PERCEPTRON_NUMBER + LANES - 1) / LANES;
    localparam int WMAX_REF  = (1 << (WIDTH - 1)) - 1;
    localparam int WMIN_REF  = -(1 << (WIDTH - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    train_state_e dbg_state;

    perceptron_train_if bus();

    perceptron_train dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int model [TABLE_DEPTH][PERCEPTRON_NUMBER];

    function automatic bit ref_train(input int sum, input bit outcome);
        longint mag;
        bit     predicted;
        mag       = (sum < 0) ? -longint'(sum) : longint'(sum);
        predicted = (sum >= 0);
        return (predicted != outcome) || (mag <= THRESHOLD);
    endfunction

    task automatic ref_apply(input int idx, input logic [PERCEPTRON_NUMBER-1:0] hist, input bit outcome);
        int w;
        for (int i = 0; i < PERCEPTRON_NUMBER; i++) begin
            w = model[idx][i] + ((hist[i] == outcome) ? 1 : -1);
            if (w > WMAX_REF) w = WMAX_REF;
            if (w < WMIN_REF) w = WMIN_REF;
            model[idx][i] = w;
        end
    endtask

    task automatic ref_clear();
        for (int r = 0; r < TABLE_DEPTH; r++)
            for (int i = 0; i < PERCEPTRON_NUMBER; i++) model[r][i] = 0;
    endtask

    function automatic row_t ref_row(input int idx);
        row_t r;
        for (int i = 0; i < PERCEPTRON_NUMBER; i++) r[i] = WIDTH'(model[idx][i]);
        return r;
    endfunction

    task automatic check_val(input string tag, input longint obs, input longint exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag, input int idx);
        row_t exp;
        exp = ref_row(idx);
        bus.pred_index = IDX_W'(idx);
        #1;
        compared++;
        assert (bus.pred_weights === exp) else begin
            mismatched++;
            $error("FAIL %s row%0d observed=%h expected=%h", tag, idx, bus.pred_weights, exp);
        end
    endtask

    task automatic check_const_row(input string tag, input int idx, input int val);
        row_t exp;
        for (int i = 0; i < PERCEPTRON_NUMBER; i++) exp[i] = WIDTH'(val);
        bus.pred_index = IDX_W'(idx);
        #1;
        compared++;
        assert (bus.pred_weights === exp) else begin
            mismatched++;
            $error("FAIL %s row%0d observed=%h expected=%h", tag, idx, bus.pred_weights, exp);
        end
    endtask

    task automatic do_request(input string tag, input int idx, input logic [PERCEPTRON_NUMBER-1:0] hist,
                              input bit outcome, input int sum);
        bit exp_train;
        int exp_lat;
        int cycles;
        bit seen;
        exp_train = ref_train(sum, outcome);
        exp_lat   = exp_train ? 2 + STEPS_REF : 2;
        @(negedge clk);
        bus.upd_valid   = 1'b1;
        bus.upd_index   = IDX_W'(idx);
        bus.upd_history = hist;
        bus.upd_outcome = outcome;
        bus.upd_sum     = sum;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.upd_ready) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check_val({tag, " accept"}, seen, 1);
        if (!seen) begin bus.upd_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        cycles = 1;
        seen   = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.upd_done) begin seen = 1'b1; break; end
            @(negedge clk);
            cycles++;
        end
        check_val({tag, " done"}, seen, 1);
        check_val({tag, " latency"}, cycles, exp_lat);
        check_val({tag, " trained"}, bus.upd_trained, exp_train);
        if (exp_train) ref_apply(idx, hist, outcome);
        @(negedge clk);
        check_val({tag, " done_pulse"}, bus.upd_done, 0);
        check_val({tag, " ready_back"}, bus.upd_ready, 1);
        check_row({tag, " row"}, idx);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.upd_valid = 1'b0;
        ref_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [PERCEPTRON_NUMBER-1:0] h1, h2;
    logic [63:0]                  rnd;
    row_t                         old_row, new_row;
    int                           accepts, cyc, rsum, ridx;
    bit                           done_seen, b_done;

    initial begin
        bus.pred_index  = '0;
        bus.upd_valid   = 1'b0;
        bus.upd_index   = '0;
        bus.upd_history = '0;
        bus.upd_outcome = NOT_TAKEN;
        bus.upd_sum     = '0;
        rst_n           = 1'b0;
        ref_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_val("reset ready", bus.upd_ready, 1);
        check_val("reset done", bus.upd_done, 0);
        check_val("reset trained", bus.upd_trained, 0);
        check_val("reset state", dbg_state, ST_IDLE);
        check_const_row("reset", 0, 0);
        check_const_row("reset", 63, 0);

        // Train on a zero sum, then a confident correct prediction skips
        do_request("train_zero", 5, '1, TAKEN, 0);
        check_const_row("row5_plus1", 5, 1);
        check_const_row("row4_untouched", 4, 0);
        do_request("skip_confident", 5, '1, TAKEN, 200);
        check_const_row("row5_after_skip", 5, 1);

        // Threshold and mispredict boundaries
        do_request("thr_pos_133", 6, {31{2'b10}}, TAKEN, 133);
        do_request("thr_pos_134", 6, {31{2'b10}}, TAKEN, 134);
        do_request("thr_neg_133", 6, {31{2'b01}}, NOT_TAKEN, -133);
        do_request("thr_neg_134", 6, {31{2'b01}}, NOT_TAKEN, -134);
        do_request("mispred_neg", 6, {31{2'b10}}, TAKEN, -1);
        do_request("mispred_pos", 6, {31{2'b10}}, NOT_TAKEN, 500);

        // Saturation at both ends
        for (int n = 0; n < 130; n++) do_request("sat_low", 7, '0, TAKEN, 0);
        check_const_row("sat_low_final", 7, WMIN_REF);
        for (int n = 0; n < 260; n++) do_request("sat_high", 7, '1, TAKEN, 0);
        check_const_row("sat_high_final", 7, WMAX_REF);

        // Coherency on row 5 while a second request is held valid through the busy period
        rnd = {$urandom, $urandom}; h1 = rnd[PERCEPTRON_NUMBER-1:0];
        rnd = {$urandom, $urandom}; h2 = rnd[PERCEPTRON_NUMBER-1:0];
        old_row = ref_row(5);
        ref_apply(5, h1, TAKEN);
        new_row = ref_row(5);
        @(negedge clk);
        bus.pred_index  = 5;
        bus.upd_valid   = 1'b1;
        bus.upd_index   = 5;
        bus.upd_history = h1;
        bus.upd_outcome = TAKEN;
        bus.upd_sum     = -7;
        check_val("coh ready_first", bus.upd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.upd_index   = 9;
        bus.upd_history = h2;
        bus.upd_outcome = NOT_TAKEN;
        bus.upd_sum     = 10;
        accepts = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.upd_valid && bus.upd_ready) begin
                accepts++;
                check_val("coh accept_after_done", done_seen, 1);
                check_val("coh new_row_at_idle", bus.pred_weights === new_row, 1);
                break;
            end
            if (bus.upd_done) begin
                done_seen = 1'b1;
                check_val("coh commit_row_whole", (bus.pred_weights === old_row) || (bus.pred_weights === new_row), 1);
            end else begin
                check_val("coh old_row_busy", bus.pred_weights === old_row, 1);
            end
            @(negedge clk);
        end
        check_val("coh accepts", accepts, 1);
        @(posedge clk);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        b_done = 1'b0;
        cyc = 1;
        for (int k = 0; k < 50; k++) begin
            if (bus.upd_done) begin b_done = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
        check_val("held_req done", b_done, 1);
        check_val("held_req latency", cyc, 2 + STEPS_REF);
        ref_apply(9, h2, NOT_TAKEN);
        @(negedge clk);
        check_row("held_req row9", 9);
        check_row("held_req row5", 5);

        // Random requests against the model
        for (int r = 0; r < 24; r++) begin
            rnd  = {$urandom, $urandom};
            ridx = 10 + int'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       rsum = int'($urandom_range(0, 300)) - 150;
                1:       rsum = int'($urandom);
                default: rsum = ($urandom_range(0, 1) == 1) ? 134 : -133;
            endcase
            do_request("rand", ridx, rnd[PERCEPTRON_NUMBER-1:0], 1'($urandom_range(0, 1)), rsum);
            check_row("rand other", int'($urandom_range(0, TABLE_DEPTH - 1)));
        end

        // Reset in the middle of an update, then the most negative sum
        do_request("pre_reset", 3, '1, TAKEN, 0);
        @(negedge clk);
        bus.upd_valid   = 1'b1;
        bus.upd_index   = 3;
        bus.upd_history = '0;
        bus.upd_outcome = TAKEN;
        bus.upd_sum     = 0;
        @(posedge clk);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_val("mid state_update", dbg_state, ST_UPDATE);
        rst_n = 1'b0;
        #1;
        check_val("mid_reset ready", bus.upd_ready, 1);
        check_val("mid_reset done", bus.upd_done, 0);
        check_val("mid_reset state", dbg_state, ST_IDLE);
        apply_reset();
        @(negedge clk);
        check_const_row("post_reset", 3, 0);
        check_const_row("post_reset", 7, 0);
        check_const_row("post_reset", 9, 0);
        rnd = {$urandom, $urandom};
        do_request("min_sum_taken", 3, rnd[PERCEPTRON_NUMBER-1:0], TAKEN, 32'sh8000_0000);
        do_request("min_sum_not_taken", 4, rnd[PERCEPTRON_NUMBER-1:0], NOT_TAKEN, 32'sh8000_0000);
        check_const_row("min_sum_row4", 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
